lcd_pattern_timing: RTL and testbench
=====================================

// Module: lcd_pattern_timing
// PURPOSE
//  Pixel source for the 480x272 RGB LCD panel. Sits between the rPLL system clock and the panel pins.
//  Divides CLK (90 MHz) down to a pixel strobe and the panel clock, and generates HSYNC, VSYNC and DE.
//  Also produces a selectable RGB565 test pattern that is aligned to DE.
//  Single clock domain; the panel clock is a registered output, not a clock net.
// PARAMETERS
//  CLK_DIV   10   CLK cycles per pixel (even, >=4); 90 MHz/10 = 9 MHz pixel rate
//  H_ACTIVE  480  visible pixels per line (multiple of 8)
//  H_FP      8    horizontal front porch, pixels
//  H_SYNC    4    HSYNC width, pixels
//  H_BP      43   horizontal back porch, pixels
//  V_ACTIVE  272  visible lines
//  V_FP      8    vertical front porch, lines
//  V_SYNC    4    VSYNC width, lines
//  V_BP      12   vertical back porch, lines
// PORTS
//  CLK          in   1   system clock (90 MHz)
//  nRST         in   1   asynchronous active-low reset
//  mode         in   2   pattern select; sampled only at frame start
//  solid_rgb    in   16  RGB565 colour for mode 3; sampled only at frame start
//  LCD_PCLK     out  1   panel pixel clock, 50% duty, period CLK_DIV
//  LCD_HSYNC    out  1   active-low horizontal sync
//  LCD_VSYNC    out  1   active-low vertical sync
//  LCD_DE       out  1   data enable, high for visible pixels
//  LCD_R        out  5   red; LCD_G out 6 green; LCD_B out 5 blue
//  pix_x        out  9   visible column 0..H_ACTIVE-1, valid when LCD_DE=1
//  pix_y        out  9   visible row 0..V_ACTIVE-1, valid when LCD_DE=1
//  frame_start  out  1   one-CLK pulse marking the first pixel period of each frame
//  frame_cnt    out  16  frames completed since reset; wraps at 65535 -> 0
// BEHAVIOUR
//  Pixel strobe: div_cnt runs 0..CLK_DIV-1. pix_ce=1 when div_cnt==CLK_DIV-1.
//   LCD_PCLK=1 while div_cnt<CLK_DIV/2. Outputs update when div_cnt wraps to 0, which is the PCLK
//   rising edge, so data is stable on the falling edge.
//  Counters: h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (535).
//   v_cnt runs 0..V_TOTAL-1 (296) and advances on the pix_ce where h_cnt wraps. Both advance only on pix_ce.
//  Line order: sync, then back porch, then active, then front porch.
//   HSYNC=0 for h<H_SYNC; DE when H_SYNC+H_BP <= h < H_SYNC+H_BP+H_ACTIVE and the v window matches
//   the same rule.
//  All LCD_*, pix_x, pix_y and frame_start are registered from the counters on pix_ce, giving one pixel
//   of latency. Pattern colour is computed from the same counters, so RGB is exactly aligned with DE.
//  RGB is forced to 0 whenever DE=0. pix_x and pix_y hold their last value while DE=0.
//  Patterns (pattern state = frame_mode, latched with solid_rgb when h=v=0 on pix_ce):
//   0: colour bars, 8 bars of H_ACTIVE/8 px, in the order white, yellow, cyan, green, magenta,
//      red, blue, black. The bar index comes from a run counter, not a divider.
//   1: gradient, R=x[8:4], G=y[8:3], B=x[8:4]^y[8:4].
//   2: checkerboard, 16x16 cells, white when x[4]^y[4]=0, else black.
//   3: solid colour from latched solid_rgb.
//  frame_start=1 for the single CLK cycle after the pix_ce where the counters wrap to (0,0).
//   frame_cnt increments in that same cycle.
//  A mode change mid-frame has no effect until the next frame start; there is never a partial-frame switch.
//  Reset (async assert, released synchronously by nRST deassert). State after reset:
//   div_cnt=0, h=v=0, HSYNC=VSYNC=1, DE=0, RGB=0, LCD_PCLK=1, pix_x=pix_y=0.
//   frame_start=0, frame_cnt=0, frame_mode=0.
//  The first pix_ce occurs CLK_DIV cycles after release. The first frame_start occurs on the first wrap
//   to (0,0), not at release.
//  Reset asserted mid-frame: all outputs go to their reset values immediately; no partial line completes.
// TESTING
//  1 Release reset. PCLK period is 10 CLK with 5 high; first pix_ce is at CLK 10;
//    HSYNC is low for 4 pixels per 535-pixel line.
//  2 Full frame. Count 296 lines with VSYNC low for 4 of them; DE is high for exactly 480x272 pixels;
//    one frame_start per frame; frame_cnt=3 after 3 frames.
//  3 Mode 0. Line y=0: x=0..59 gives FFFF, x=60 gives FFE0, x=120 gives 07FF, x=420..479 gives 0000.
//    RGB is 0 in the porches.
//  4 Mode 2. (x,y)=(15,0) is FFFF, (16,0) is 0000, (16,16) is FFFF.
//    Mode 3 with solid_rgb=F800 makes every DE pixel F800.
//  5 Switch mode 0->3 at line 100. The rest of the frame stays bars; the next frame is solid.
//    solid_rgb changing mid-frame is likewise ignored until the next frame.
//  6 Assert nRST at h=200, v=150. Outputs take reset values within the same cycle;
//    after release, timing restarts from h=v=0.

Source files
------------

// File: rtl/lcd_pattern_timing.sv
`timescale 1ns/1ps
`default_nettype none
// lcd_pattern_timing: RGB LCD timing generator (PCLK, HSYNC, VSYNC, DE) with DE-aligned RGB565 test patterns.
// Rev 1.0
module lcd_pattern_timing #(
  parameter int CLK_DIV  = 10,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        LCD_PCLK,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        LCD_DE,
  output logic [4:0]  LCD_R,
  output logic [5:0]  LCD_G,
  output logic [4:0]  LCD_B,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int DW      = $clog2(CLK_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [DW-1:0] r_div;
  logic          r_pclk;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [BW-1:0] r_bar_run;
  logic [2:0]    r_bar_idx;
  logic [1:0]    r_frame_mode;
  logic [15:0]   r_solid;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [15:0]   r_rgb;
  logic [8:0]    r_pix_x;
  logic [8:0]    r_pix_y;
  logic          r_frame_start;
  logic [15:0]   r_frame_cnt;

  logic          w_pix_ce;
  logic [DW-1:0] w_div_nxt;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_de;
  logic          w_frame_top;
  logic          w_frame_wrap;
  logic [8:0]    w_x;
  logic [8:0]    w_y;
  logic [15:0]   w_rgb;

  // Pixel strobe; PCLK is registered from the next divider value so its edges line up with r_div.
  assign w_pix_ce  = (r_div == DW'(CLK_DIV - 1));
  assign w_div_nxt = w_pix_ce ? '0 : r_div + DW'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_div  <= '0;
      r_pclk <= 1'b1;
    end else begin
      r_div  <= w_div_nxt;
      r_pclk <= (w_div_nxt < DW'(CLK_DIV / 2));
    end
  end

  assign w_h_last     = (r_h == HW'(H_TOTAL - 1));
  assign w_v_last     = (r_v == VW'(V_TOTAL - 1));
  assign w_frame_top  = (r_h == '0) && (r_v == '0);
  assign w_frame_wrap = w_pix_ce && w_h_last && w_v_last;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_ce) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  assign w_h_act = (r_h >= HW'(H_START)) && (r_h < HW'(H_END));
  assign w_v_act = (r_v >= VW'(V_START)) && (r_v < VW'(V_END));
  assign w_de    = w_h_act && w_v_act;
  assign w_x     = 9'(r_h - HW'(H_START));
  assign w_y     = 9'(r_v - VW'(V_START));

  // Bar index follows x via a run-length counter, cleared outside the active part of each line.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_bar_run <= '0;
      r_bar_idx <= '0;
    end else if (w_pix_ce) begin
      if (!w_h_act) begin
        r_bar_run <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_run == BW'(BAR_W - 1)) begin
        r_bar_run <= '0;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_run <= r_bar_run + BW'(1);
      end
    end
  end

  // Pattern controls only change at the top of a frame, never mid-frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_frame_mode <= 2'd0;
      r_solid      <= 16'h0000;
    end else if (w_pix_ce && w_frame_top) begin
      r_frame_mode <= mode;
      r_solid      <= solid_rgb;
    end
  end

  always_comb begin
    w_rgb = 16'h0000;
    case (r_frame_mode)
      2'd0: begin
        case (r_bar_idx)
          3'd0:    w_rgb = 16'hFFFF;
          3'd1:    w_rgb = 16'hFFE0;
          3'd2:    w_rgb = 16'h07FF;
          3'd3:    w_rgb = 16'h07E0;
          3'd4:    w_rgb = 16'hF81F;
          3'd5:    w_rgb = 16'hF800;
          3'd6:    w_rgb = 16'h001F;
          default: w_rgb = 16'h0000;
        endcase
      end
      2'd1:    w_rgb = {w_x[8:4], w_y[8:3], w_x[8:4] ^ w_y[8:4]};
      2'd2:    w_rgb = (w_x[4] ^ w_y[4]) ? 16'h0000 : 16'hFFFF;
      default: w_rgb = r_solid;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_rgb   <= 16'h0000;
      r_pix_x <= 9'd0;
      r_pix_y <= 9'd0;
    end else if (w_pix_ce) begin
      r_hsync <= !(r_h < HW'(H_SYNC));
      r_vsync <= !(r_v < VW'(V_SYNC));
      r_de    <= w_de;
      r_rgb   <= w_de ? w_rgb : 16'h0000;
      if (w_de) begin
        r_pix_x <= w_x;
        r_pix_y <= w_y;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 16'd0;
    end else begin
      r_frame_start <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign LCD_PCLK    = r_pclk;
  assign LCD_HSYNC   = r_hsync;
  assign LCD_VSYNC   = r_vsync;
  assign LCD_DE      = r_de;
  assign LCD_R       = r_rgb[15:11];
  assign LCD_G       = r_rgb[10:5];
  assign LCD_B       = r_rgb[4:0];
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lcd_pattern_timing.sv
`timescale 1ns/1ps
`default_nettype none
// tb_lcd_pattern_timing: randomized mode/colour stimulus against a cycle-count based reference model.
// Rev 1.0
module tb_lcd_pattern_timing;

  localparam int CLK_DIV  = 6;
  localparam int H_ACTIVE = 32;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 20;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START  = H_SYNC + H_BP;
  localparam int V_START  = V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        LCD_PCLK, LCD_HSYNC, LCD_VSYNC, LCD_DE;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic [8:0]  pix_x, pix_y;
  logic        frame_start;
  logic [15:0] frame_cnt;

  lcd_pattern_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .CLK(CLK), .nRST(nRST), .mode(mode), .solid_rgb(solid_rgb),
    .LCD_PCLK(LCD_PCLK), .LCD_HSYNC(LCD_HSYNC), .LCD_VSYNC(LCD_VSYNC), .LCD_DE(LCD_DE),
    .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  int          n_err = 0;
  int          n_chk = 0;
  int          c = 0;
  int          exp_mode = 0;
  logic [15:0] exp_solid = 16'h0000;
  int          exp_px = 0;
  int          exp_py = 0;
  int          nxt_chg = 1000;
  int          nxt_sol = 300;
  int          chg_idx = 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (c=%0d t=%0t)", tag, obs, exp, c, $time);
    end
  endtask

  function automatic logic [15:0] ref_colour(int m, int x, int y, logic [15:0] s);
    logic [15:0] bars [8];
    int r, g, b;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    case (m)
      0: return bars[x / (H_ACTIVE / 8)];
      1: begin
        r = (x / 16) % 32;
        g = (y / 8) % 64;
        b = ((x / 16) ^ (y / 16)) % 32;
        return 16'(r * 2048 + g * 32 + b);
      end
      2: return (((x / 16) + (y / 16)) % 2 == 0) ? 16'hFFFF : 16'h0000;
      default: return s;
    endcase
  endfunction

  // Expected outputs after c clock edges since reset release.
  task automatic check_cycle();
    int p, k, h, v;
    logic hs, vs, de, fs;
    logic [15:0] rgb;
    p   = c / CLK_DIV;
    hs  = 1'b1; vs = 1'b1; de = 1'b0; fs = 1'b0; rgb = 16'h0000;
    if (p > 0) begin
      k  = p - 1;
      h  = k % H_TOTAL;
      v  = (k / H_TOTAL) % V_TOTAL;
      hs = (h >= H_SYNC);
      vs = (v >= V_SYNC);
      de = (h >= H_START) && (h < H_START + H_ACTIVE) && (v >= V_START) && (v < V_START + V_ACTIVE);
      if (de) begin
        exp_px = h - H_START;
        exp_py = v - V_START;
        rgb    = ref_colour(exp_mode, exp_px, exp_py, exp_solid);
      end
      fs = ((c % CLK_DIV) == 0) && ((p % FRAME) == 0);
    end
    check_eq("pclk", LCD_PCLK, ((c % CLK_DIV) < (CLK_DIV / 2)));
    check_eq("hsync", LCD_HSYNC, hs);
    check_eq("vsync", LCD_VSYNC, vs);
    check_eq("de", LCD_DE, de);
    check_eq("rgb", {LCD_R, LCD_G, LCD_B}, rgb);
    check_eq("pix_x", pix_x, exp_px);
    check_eq("pix_y", pix_y, exp_py);
    check_eq("frame_start", frame_start, fs);
    check_eq("frame_cnt", frame_cnt, (p / FRAME) % 65536);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_pclk"}, LCD_PCLK, 1);
    check_eq({pfx, "_hsync"}, LCD_HSYNC, 1);
    check_eq({pfx, "_vsync"}, LCD_VSYNC, 1);
    check_eq({pfx, "_de"}, LCD_DE, 0);
    check_eq({pfx, "_rgb"}, {LCD_R, LCD_G, LCD_B}, 0);
    check_eq({pfx, "_pix_x"}, pix_x, 0);
    check_eq({pfx, "_pix_y"}, pix_y, 0);
    check_eq({pfx, "_fs"}, frame_start, 0);
    check_eq({pfx, "_fcnt"}, frame_cnt, 0);
  endtask

  // Entered and left on a falling edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      if (nxt_chg == 0) begin
        mode    = 2'(chg_idx % 4);
        chg_idx++;
        nxt_chg = $urandom_range(1500, 2500);
      end else begin
        nxt_chg--;
      end
      if (nxt_sol == 0) begin
        solid_rgb = 16'($urandom);
        nxt_sol   = $urandom_range(200, 900);
      end else begin
        nxt_sol--;
      end
      if ((((c + 1) % CLK_DIV) == 0) && ((((c + 1) / CLK_DIV - 1) % FRAME) == 0)) begin
        exp_mode  = int'(mode);
        exp_solid = solid_rgb;
      end
      @(posedge CLK);
      c++;
      @(negedge CLK);
    end
  endtask

  initial begin
    solid_rgb = 16'hF800;
    repeat (3) @(negedge CLK);
    check_reset_vals("rst");
    nRST = 1'b1;
    c    = 0;
    run_cycles(4 * FRAME * CLK_DIV + 2700);

    nRST = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge CLK);
    @(negedge CLK);
    check_reset_vals("midrst_hold");
    nRST      = 1'b1;
    c         = 0;
    exp_px    = 0;
    exp_py    = 0;
    exp_mode  = 0;
    exp_solid = 16'h0000;
    run_cycles(2 * FRAME * CLK_DIV + 50);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
